// File: rtl/fifo_param_ctrl.sv
// Parametrised synchronous FIFO controller with status flags, sticky error flags,
// synchronous flush and selectable standard or first-word-fall-through read data.
module fifo_param_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             data,
  input  logic                         wr_data,
  input  logic                         rd_data,
  input  logic                         flush,
  input  logic                         err_clr,
  output logic [WIDTH-1:0]             out_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_param_ctrl: DEPTH must be a power of two and at least 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("fifo_param_ctrl: levels must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             full_reg, empty_reg, af_reg, ae_reg;
  logic             overflow_reg, underflow_reg;
  logic             wr_acc, rd_acc, ovf_evt, udf_evt;

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  always_comb begin
    rd_acc     = rd_data && !empty_reg && !flush;
    wr_acc     = wr_data && (!full_reg || rd_acc) && !flush;
    ovf_evt    = wr_data && full_reg && !rd_acc && !flush;
    udf_evt    = rd_data && empty_reg && !flush;
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_reg] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_CNT);
      empty_reg <= (count_next == '0);
      af_reg    <= (count_next >= AF_CNT);
      ae_reg    <= (count_next <= AE_CNT);
    end
  end

  // Error flags are sticky; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= (overflow_reg && !err_clr) || ovf_evt;
      underflow_reg <= (underflow_reg && !err_clr) || udf_evt;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign out_data = empty_reg ? '0 : mem[rd_ptr_reg];
  end else begin : g_std
    logic [WIDTH-1:0] out_reg;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset)      out_reg <= '0;
      else if (rd_acc) out_reg <= mem[rd_ptr_reg];
    end
    assign out_data = out_reg;
  end

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_param_ctrl.sv
// Directed bench for fifo_param_ctrl: one standard-read and one FWFT instance,
// both DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_param_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] d0_data, d0_out;
  logic       d0_wr, d0_rd, d0_flush, d0_clr;
  logic       d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
  logic [2:0] d0_count;

  logic [7:0] d1_data, d1_out;
  logic       d1_wr, d1_rd, d1_flush, d1_clr;
  logic       d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;
  logic [2:0] d1_count;

  int n_checks = 0;
  int n_errors = 0;

  fifo_param_ctrl #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut_std (
    .clock(clock), .reset(reset), .data(d0_data), .wr_data(d0_wr), .rd_data(d0_rd),
    .flush(d0_flush), .err_clr(d0_clr), .out_data(d0_out), .full(d0_full),
    .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
    .overflow(d0_ovf), .underflow(d0_udf)
  );

  fifo_param_ctrl #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_fwft (
    .clock(clock), .reset(reset), .data(d1_data), .wr_data(d1_wr), .rd_data(d1_rd),
    .flush(d1_flush), .err_clr(d1_clr), .out_data(d1_out), .full(d1_full),
    .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
    .overflow(d1_ovf), .underflow(d1_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic wr, input logic rd, input logic [7:0] d,
                        input logic fl, input logic ec);
    d0_wr = wr; d0_rd = rd; d0_data = d; d0_flush = fl; d0_clr = ec;
  endtask

  task automatic drive1(input logic wr, input logic rd, input logic [7:0] d,
                        input logic fl, input logic ec);
    d1_wr = wr; d1_rd = rd; d1_data = d; d1_flush = fl; d1_clr = ec;
  endtask

  initial begin
    drive0(0, 0, 8'h00, 0, 0);
    drive1(0, 0, 8'h00, 0, 0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;

    // reset state
    check("rst_empty", d0_empty, 1);
    check("rst_full", d0_full, 0);
    check("rst_af", d0_af, 0);
    check("rst_ae", d0_ae, 1);
    check("rst_count", d0_count, 0);
    check("rst_ovf", d0_ovf, 0);
    check("rst_udf", d0_udf, 0);
    check("rst_out", d0_out, 0);
    check("rst_fwft_out", d1_out, 0);

    // 1: three writes, three reads, 1-cycle read latency
    drive0(1, 0, 8'h02, 0, 0); tick();
    check("t1_count1", d0_count, 1);
    check("t1_ae1", d0_ae, 1);
    check("t1_empty", d0_empty, 0);
    drive0(1, 0, 8'h06, 0, 0); tick();
    check("t1_count2", d0_count, 2);
    check("t1_ae2", d0_ae, 0);
    drive0(1, 0, 8'h0E, 0, 0); tick();
    check("t1_count3", d0_count, 3);
    check("t1_af3", d0_af, 1);
    check("t1_out_hold", d0_out, 0);
    drive0(0, 1, 8'h00, 0, 0); tick();
    check("t1_rd0", d0_out, 8'h02);
    check("t1_count2b", d0_count, 2);
    check("t1_af2", d0_af, 0);
    tick();
    check("t1_rd1", d0_out, 8'h06);
    check("t1_count1b", d0_count, 1);
    tick();
    check("t1_rd2", d0_out, 8'h0E);
    check("t1_count0", d0_count, 0);
    check("t1_empty_end", d0_empty, 1);

    // 2: overfill by one
    for (int i = 0; i < 5; i++) begin
      drive0(1, 0, 8'h10 + 8'(i), 0, 0); tick();
      if (i == 3) begin
        check("t2_full", d0_full, 1);
        check("t2_count4", d0_count, 4);
        check("t2_no_ovf_yet", d0_ovf, 0);
      end
    end
    check("t2_ovf", d0_ovf, 1);
    check("t2_count_stays", d0_count, 4);
    check("t2_out_hold", d0_out, 8'h0E);
    drive0(0, 0, 8'h00, 0, 1); tick();
    check("t2_ovf_clr", d0_ovf, 0);

    // 3: read+write on full, then drain across the pointer wrap
    drive0(1, 1, 8'h1E, 0, 0); tick();
    check("t3_out", d0_out, 8'h10);
    check("t3_count", d0_count, 4);
    check("t3_full", d0_full, 1);
    check("t3_no_ovf", d0_ovf, 0);
    drive0(0, 1, 8'h00, 0, 0);
    tick(); check("t3_drain0", d0_out, 8'h11);
    tick(); check("t3_drain1", d0_out, 8'h12);
    tick(); check("t3_drain2", d0_out, 8'h13);
    tick(); check("t3_drain3", d0_out, 8'h1E);
    check("t3_empty", d0_empty, 1);

    // 4: underflow, then rd+wr on empty
    tick();
    check("t4_udf", d0_udf, 1);
    check("t4_count", d0_count, 0);
    check("t4_out_hold", d0_out, 8'h1E);
    drive0(1, 1, 8'h55, 0, 0); tick();
    check("t4_count1", d0_count, 1);
    check("t4_udf_sticky", d0_udf, 1);
    check("t4_out_hold2", d0_out, 8'h1E);
    drive0(0, 1, 8'h00, 0, 0); tick();
    check("t4_pop", d0_out, 8'h55);
    drive0(0, 0, 8'h00, 0, 0);

    // 5: FWFT instance
    drive1(1, 0, 8'hA5, 0, 0); tick();
    check("t5_out_a5", d1_out, 8'hA5);
    check("t5_empty", d1_empty, 0);
    drive1(1, 0, 8'h5A, 0, 0); tick();
    check("t5_head_hold", d1_out, 8'hA5);
    check("t5_count2", d1_count, 2);
    drive1(0, 1, 8'h00, 0, 0); tick();
    check("t5_pop1", d1_out, 8'h5A);
    drive1(0, 1, 8'h00, 0, 0); tick();
    check("t5_pop2", d1_out, 8'h00);
    check("t5_empty_end", d1_empty, 1);
    check("t5_no_udf", d1_udf, 0);
    drive1(1, 0, 8'hC3, 0, 0); tick();
    check("t5_out_c3", d1_out, 8'hC3);
    drive1(0, 0, 8'h00, 1, 0); tick();
    check("t5_flush_out", d1_out, 8'h00);
    check("t5_flush_empty", d1_empty, 1);
    drive1(0, 0, 8'h00, 0, 0);

    // 6: almost flags, flush with write, async reset mid-write
    drive0(0, 0, 8'h00, 0, 1); tick();
    check("t6_udf_clr", d0_udf, 0);
    drive0(1, 0, 8'h31, 0, 0); tick();
    check("t6_ae_c1", d0_ae, 1);
    drive0(1, 0, 8'h32, 0, 0); tick();
    check("t6_ae_c2", d0_ae, 0);
    drive0(1, 0, 8'h33, 0, 0); tick();
    check("t6_af", d0_af, 1);
    check("t6_not_full", d0_full, 0);
    drive0(1, 0, 8'h99, 1, 0); tick();
    check("t6_flush_count", d0_count, 0);
    check("t6_flush_empty", d0_empty, 1);
    check("t6_flush_ae", d0_ae, 1);
    check("t6_flush_af", d0_af, 0);
    check("t6_flush_out", d0_out, 8'h55);
    drive0(0, 1, 8'h00, 0, 0); tick();
    check("t6_udf", d0_udf, 1);
    drive0(1, 0, 8'h40, 0, 0); tick();
    check("t6_count1", d0_count, 1);
    drive0(1, 0, 8'h41, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_count", d0_count, 0);
    check("t6_rst_empty", d0_empty, 1);
    check("t6_rst_ae", d0_ae, 1);
    check("t6_rst_af", d0_af, 0);
    check("t6_rst_udf", d0_udf, 0);
    check("t6_rst_out", d0_out, 0);
    drive0(1, 0, 8'h77, 0, 0);
    #2 reset = 1'b1;
    tick();
    check("t6_post_rst_count", d0_count, 1);
    drive0(0, 1, 8'h00, 0, 0); tick();
    check("t6_post_rst_rd", d0_out, 8'h77);
    drive0(0, 0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
